pipelined_adder: RTL and testbench

PIPELINED_ADDER -- requirements
Module: pipelined_adder

---
 rtl/pipelined_adder.sv | 128 ++++++++++++
 tb/tb_pipelined_adder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder.sv
// Segmented carry-ripple adder: one pipeline stage per SEG_WIDTH-bit slice, NSTAGE cycles latency.
// Backpressure stalls the whole pipe (in_ready = out_ready | ~out_valid); optional PIPELINED_ADDER_SUB_EN adds a subtract port.
module pipelined_adder #(
    parameter int WIDTH     = 8,
    parameter int SEG_WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
`ifdef PIPELINED_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int SEG_W  = (SEG_WIDTH < 1) ? 1 : SEG_WIDTH;
    localparam int NSTAGE = (WIDTH / SEG_W < 1) ? 1 : WIDTH / SEG_W;

    generate
        if (SEG_WIDTH < 1 || (WIDTH % SEG_W) != 0) begin : g_bad_cfg
            $error("pipelined_adder: WIDTH must be a positive multiple of SEG_WIDTH");
        end
    endgenerate

    logic              adv;
    logic [NSTAGE-1:0] vld_q, vld_d;
    logic [NSTAGE-1:0] cy_q, cy_d;
    logic [WIDTH-1:0]  a_q   [NSTAGE];
    logic [WIDTH-1:0]  a_d   [NSTAGE];
    logic [WIDTH-1:0]  b_q   [NSTAGE];
    logic [WIDTH-1:0]  b_d   [NSTAGE];
    logic [WIDTH-1:0]  sum_q [NSTAGE];
    logic [WIDTH-1:0]  sum_d [NSTAGE];
    logic              ovf_q, ovf_d;

    logic [WIDTH-1:0]  b_eff;
    logic              cin_eff;
    logic              cur_v;
    logic              cur_c;
    logic [WIDTH-1:0]  cur_a, cur_b, cur_s, nxt_s;
    logic [SEG_W:0]    seg;
    logic              ovf_new;

    assign adv      = out_ready | ~out_valid;
    assign in_ready = adv;

    // Subtraction folds into the adder as a + ~b + 1 at the input boundary.
`ifdef PIPELINED_ADDER_SUB_EN
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = sub ? 1'b1 : carry_in;
`else
    assign b_eff   = b;
    assign cin_eff = carry_in;
`endif

    // Walk the stages in order; cur_* is the input to stage k, i.e. the
    // ports for stage 0 and the registers of stage k-1 afterwards.
    always_comb begin
        cur_v   = in_valid;
        cur_a   = a;
        cur_b   = b_eff;
        cur_s   = '0;
        cur_c   = cin_eff;
        seg     = '0;
        nxt_s   = '0;
        ovf_new = 1'b0;
        vld_d   = vld_q;
        cy_d    = cy_q;
        for (int k = 0; k < NSTAGE; k++) begin
            seg = {1'b0, cur_a[k*SEG_W +: SEG_W]}
                + {1'b0, cur_b[k*SEG_W +: SEG_W]}
                + {{SEG_W{1'b0}}, cur_c};
            nxt_s = cur_s;
            nxt_s[k*SEG_W +: SEG_W] = seg[SEG_W-1:0];
            if (k == NSTAGE - 1) begin
                // carry into the MSB is recovered as a ^ b ^ sum at that bit
                ovf_new = cur_a[WIDTH-1] ^ cur_b[WIDTH-1] ^ seg[SEG_W-1] ^ seg[SEG_W];
            end
            vld_d[k] = adv ? cur_v : vld_q[k];
            cy_d[k]  = adv ? seg[SEG_W] : cy_q[k];
            a_d[k]   = adv ? cur_a : a_q[k];
            b_d[k]   = adv ? cur_b : b_q[k];
            sum_d[k] = adv ? nxt_s : sum_q[k];
            cur_v    = vld_q[k];
            cur_a    = a_q[k];
            cur_b    = b_q[k];
            cur_s    = sum_q[k];
            cur_c    = cy_q[k];
        end
        ovf_d = adv ? ovf_new : ovf_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            cy_q  <= '0;
            ovf_q <= 1'b0;
            for (int k = 0; k < NSTAGE; k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                sum_q[k] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            cy_q  <= cy_d;
            ovf_q <= ovf_d;
            for (int k = 0; k < NSTAGE; k++) begin
                a_q[k]   <= a_d[k];
                b_q[k]   <= b_d[k];
                sum_q[k] <= sum_d[k];
            end
        end
    end

    assign out_valid = vld_q[NSTAGE-1];
    assign sum       = sum_q[NSTAGE-1];
    assign carry_out = cy_q[NSTAGE-1];
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder (WIDTH=8, SEG_WIDTH=4): random and directed operands,
// stalls and mid-flight reset; subtract cases included when PIPELINED_ADDER_SUB_EN is defined.
module tb_pipelined_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, carry_in;
    logic       out_valid, out_ready, carry_out, overflow;
    logic [7:0] a, b, sum;
`ifdef PIPELINED_ADDER_SUB_EN
    logic       sub;
`endif

    int checks = 0;
    int errors = 0;
    int out_cnt = 0;
    logic [9:0] exp_q[$];

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(8), .SEG_WIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .carry_in(carry_in),
`ifdef PIPELINED_ADDER_SUB_EN
        .sub(sub),
`endif
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .carry_out(carry_out), .overflow(overflow)
    );

    // Reference: plain integer arithmetic, result {overflow, carry_out, sum}.
    function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y,
                                         input logic c, input logic s);
        int ua, ub, uc, tot, sa, sb, st;
        logic [7:0] sm;
        logic co, ov;
        ua  = int'(x);
        ub  = s ? 255 - int'(y) : int'(y);
        uc  = s ? 1 : int'(c);
        tot = ua + ub + uc;
        sm  = 8'(tot % 256);
        co  = (tot >= 256);
        sa  = (ua >= 128) ? ua - 256 : ua;
        sb  = (ub >= 128) ? ub - 256 : ub;
        st  = sa + sb + uc;
        ov  = (st > 127) || (st < -128);
        return {ov, co, sm};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            out_cnt++;
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_result", 32'({overflow, carry_out, sum}), 32'h7ff);
            end else begin
                chk("sb_result", 32'({overflow, carry_out, sum}), 32'(exp_q.pop_front()));
            end
        end
    end

    // One cycle: drive at posedge+1, observe at negedge, return at next posedge+1.
    // obs = {out_valid, overflow, carry_out, sum} as seen at the negedge.
    task automatic step(input logic iv, input logic [7:0] aa, input logic [7:0] bb,
                        input logic cc, input logic ss, input logic ordy,
                        output logic acc, output logic [10:0] obs, output logic rdy);
        in_valid  = iv;
        a         = aa;
        b         = bb;
        carry_in  = cc;
        out_ready = ordy;
`ifdef PIPELINED_ADDER_SUB_EN
        sub       = ss;
`endif
        @(negedge clk);
        rdy = in_ready;
        obs = {out_valid, overflow, carry_out, sum};
        acc = iv && in_ready;
        if (acc) exp_q.push_back(model(aa, bb, cc, ss));
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic ordy);
        logic acc, rdy;
        logic [10:0] obs;
        step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, ordy, acc, obs, rdy);
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) idle(1'b1);
        repeat (3) idle(1'b1);
        chk({nm, "_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    // Issue one op into an empty pipe and check the exact 2-cycle latency.
    task automatic directed(input string nm, input logic [7:0] x, input logic [7:0] y,
                            input logic c, input logic s,
                            input logic [7:0] es, input logic eco, input logic eov);
        logic acc, rdy;
        logic [10:0] obs;
        step(1'b1, x, y, c, s, 1'b1, acc, obs, rdy);
        chk({nm, "_accepted"}, 32'(acc), 32'd1);
        step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, acc, obs, rdy);
        chk({nm, "_not_early"}, 32'(obs[10]), 32'd0);
        step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, acc, obs, rdy);
        chk({nm, "_result"}, 32'(obs), 32'({1'b1, eov, eco, es}));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc, rdy, iv, ordy;
        logic [10:0] obs, held;
        logic [7:0] ra[5], rb[5];
        logic rc[5];
        int p, base_cnt, acc_n, cyc;

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; carry_in = 1'b0; out_ready = 1'b1;
`ifdef PIPELINED_ADDER_SUB_EN
        sub = 1'b0;
`endif
        @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_outputs", 32'({overflow, carry_out, sum}), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_in_ready", 32'(in_ready), 32'd1);

        directed("wrap_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        directed("ovf_7f_01",  8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        directed("seg_carry",  8'h0F, 8'h00, 1'b1, 1'b0, 8'h10, 1'b0, 1'b0);
        directed("neg_ovf",    8'h80, 8'hFF, 1'b0, 1'b0, 8'h7F, 1'b1, 1'b1);
        directed("all_ones",   8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0);
`ifdef PIPELINED_ADDER_SUB_EN
        directed("sub_5_7", 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
        directed("sub_7_5", 8'h07, 8'h05, 1'b1, 1'b1, 8'h02, 1'b1, 1'b0);
`endif

        // Five back-to-back ops with out_ready low in cycles 3..6.
        for (int i = 0; i < 5; i++) begin
            ra[i] = 8'($urandom);
            rb[i] = 8'($urandom);
            rc[i] = 1'($urandom);
        end
        p = 0;
        held = '0;
        base_cnt = out_cnt;
        for (int i = 0; i < 12; i++) begin
            ordy = !(i >= 3 && i <= 6);
            if (p < 5) step(1'b1, ra[p], rb[p], rc[p], 1'b0, ordy, acc, obs, rdy);
            else       step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, ordy, acc, obs, rdy);
            if (acc) p++;
            if (i >= 3 && i <= 6) begin
                chk("stall_in_ready", 32'(rdy), 32'd0);
                if (i == 3) begin
                    held = obs;
                    chk("stall_out_valid", 32'(obs[10]), 32'd1);
                end else begin
                    chk("stall_hold", 32'(obs), 32'(held));
                end
            end
        end
        chk("stall_issued", 32'(p), 32'd5);
        drain("stall");
        chk("stall_result_count", 32'(out_cnt - base_cnt), 32'd5);

        // Reset with two ops in flight: neither may ever emerge.
        step(1'b1, 8'h11, 8'h22, 1'b0, 1'b0, 1'b0, acc, obs, rdy);
        chk("flight_a_accepted", 32'(acc), 32'd1);
        step(1'b1, 8'h33, 8'h44, 1'b1, 1'b0, 1'b0, acc, obs, rdy);
        chk("flight_b_accepted", 32'(acc), 32'd1);
        rst = 1'b1;
        exp_q.delete();
        idle(1'b0);
        rst = 1'b0;
        base_cnt = out_cnt;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, acc, obs, rdy);
            if (i == 0) chk("post_rst_in_ready", 32'(rdy), 32'd1);
            chk("post_rst_no_output", 32'(obs[10]), 32'd0);
        end
        chk("post_rst_no_results", 32'(out_cnt - base_cnt), 32'd0);
        directed("post_rst_op", 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0);

        // Random traffic with random in_valid and out_ready.
        acc_n = 0;
        cyc = 0;
        base_cnt = out_cnt;
        while (acc_n < 1000 && cyc < 20000) begin
            iv   = ($urandom_range(0, 9) < 7);
            ordy = ($urandom_range(0, 9) < 7);
`ifdef PIPELINED_ADDER_SUB_EN
            step(iv, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), ordy, acc, obs, rdy);
`else
            step(iv, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0, ordy, acc, obs, rdy);
`endif
            if (acc) acc_n++;
            cyc++;
        end
        chk("random_issued", 32'(acc_n), 32'd1000);
        drain("random");
        chk("random_result_count", 32'(out_cnt - base_cnt), 32'(acc_n));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
